// File: rtl/memoria_pkg.sv
// memoria_pkg: shared definitions for the wait-state data memory.
// Contents: Tam size encodings, FSM state type, word-size helper.
package memoria_pkg;

    localparam logic [1:0] TAM_BYTE = 2'b00;
    localparam logic [1:0] TAM_HALF = 2'b01;
    localparam logic [1:0] TAM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ESPERA = 2'b01,
        FIN    = 2'b10
    } estado_t;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic logic es_palabra(input logic [1:0] tam);
        return tam[1];
    endfunction

endpackage

// File: rtl/memoria_lanes.sv
// memoria_lanes: byte-enable generation, write-lane placement, read align/extend.
// Ports:
//   tam   in  2       access size (TAM_BYTE / TAM_HALF / word)
//   off   in  2       byte offset within the word (already aligned by the caller)
//   sext  in  1       1 = sign-extend sub-word reads
//   din   in  DATA_W  right-aligned write data
//   rword in  DATA_W  full word read from the array
//   be    out DATA_W/8 byte enables for the write
//   wdata out DATA_W  write data placed on its lanes
//   rdata out DATA_W  read data right-aligned and extended
module memoria_lanes
    import memoria_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          tam,
    input  logic [1:0]          off,
    input  logic                sext,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W-1:0]   rword,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  rb;
    logic [15:0] rh;

    always_comb begin
        bsh   = {off, 3'b000};
        hsh   = {off[1], 4'b0000};
        rb    = 8'(rword >> bsh);
        rh    = 16'(rword >> hsh);
        be    = es_palabra(tam) ? {NB{1'b1}} :
                tam == TAM_HALF ? NB'(3) << {off[1], 1'b0} : NB'(1) << off;
        wdata = es_palabra(tam) ? din : tam == TAM_HALF ? din << hsh : din << bsh;
        rdata = es_palabra(tam) ? rword :
                tam == TAM_HALF ? {{(DATA_W-16){sext & rh[15]}}, rh} :
                                  {{(DATA_W-8){sext & rb[7]}}, rb};
    end

endmodule

// File: rtl/memoria_datos_espera.sv
// memoria_datos_espera: data memory with byte/half/word access and programmable wait states.
// Ports:
//   clk      in  1       rising-edge clock
//   reset    in  1       asynchronous active-high reset
//   EscrMem  in  1       write request (sampled in IDLE, wins over LeerMem)
//   LeerMem  in  1       read request (sampled in IDLE)
//   Direc    in  ADDR_W  byte address
//   Datain   in  DATA_W  right-aligned write data
//   Tam      in  2       access size: byte / half / word (11 = word)
//   SignoExt in  1       sign-extend sub-word reads
//   Dataout  out DATA_W  registered read data, valid with Listo, held until next read
//   Listo    out 1       one-cycle completion pulse
//   Ocupado  out 1       busy from accept through Listo
//   ErrAlin  out 1       misalignment pulse with Listo
// Configuration: define MEM_ALIN_EN to flag and suppress misaligned accesses;
// otherwise low address bits are forced to alignment and ErrAlin is 0.
module memoria_datos_espera
    import memoria_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EscrMem,
    input  logic              LeerMem,
    input  logic [ADDR_W-1:0] Direc,
    input  logic [DATA_W-1:0] Datain,
    input  logic [1:0]        Tam,
    input  logic              SignoExt,
    output logic [DATA_W-1:0] Dataout,
    output logic              Listo,
    output logic              Ocupado,
    output logic              ErrAlin
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] mem [DEPTH];

    estado_t           state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [1:0]        tam_q, tam_d;
    logic              sext_q, sext_d;
    logic              wr_q, wr_d;

    logic              idle, accept, acc_wr, acc_sext, mis;
    logic [ADDR_W-1:0] acc_dir, dir_al;
    logic [DATA_W-1:0] acc_din, rword, wdata, rdata;
    logic [1:0]        acc_tam;
    logic [NB-1:0]     be;

    // In IDLE the live inputs describe the access; afterwards the latched copy does.
    // This lets a zero-wait access load Dataout on the same edge that accepts it.
    always_comb begin
        idle     = state_q == IDLE;
        accept   = idle && (EscrMem || LeerMem);
        acc_wr   = idle ? EscrMem  : wr_q;
        acc_dir  = idle ? Direc    : dir_q;
        acc_din  = idle ? Datain   : din_q;
        acc_tam  = idle ? Tam      : tam_q;
        acc_sext = idle ? SignoExt : sext_q;
        dir_d    = accept ? Direc    : dir_q;
        din_d    = accept ? Datain   : din_q;
        tam_d    = accept ? Tam      : tam_q;
        sext_d   = accept ? SignoExt : sext_q;
        wr_d     = accept ? EscrMem  : wr_q;
    end

`ifdef MEM_ALIN_EN
    always_comb begin
        mis     = (acc_tam == TAM_HALF && acc_dir[0]) ||
                  (es_palabra(acc_tam) && acc_dir[1:0] != 2'b00);
        dir_al  = acc_dir;
        ErrAlin = Listo && mis;
    end
`else
    always_comb begin
        mis     = 1'b0;
        dir_al  = es_palabra(acc_tam) ? {acc_dir[ADDR_W-1:2], 2'b00} :
                  acc_tam == TAM_HALF ? {acc_dir[ADDR_W-1:1], 1'b0} : acc_dir;
        ErrAlin = 1'b0;
    end
`endif

    assign rword = mem[dir_al[ADDR_W-1:2]];

    memoria_lanes #(.DATA_W(DATA_W)) u_lanes (
        .tam   (acc_tam),
        .off   (dir_al[1:0]),
        .sext  (acc_sext),
        .din   (acc_din),
        .rword (rword),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            tam_q   <= '0;
            sext_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            tam_q   <= tam_d;
            sext_q  <= sext_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = WAIT_CYC == 0 ? FIN : ESPERA;
                cnt_d   = 4'(WAIT_CYC);
            end
            ESPERA: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q <= 4'd1 ? FIN : ESPERA;
            end
            default: state_d = IDLE;
        endcase
        // Dataout is loaded on the edge entering FIN so it is valid alongside Listo.
        dout_d = (state_d == FIN && state_q != FIN && !acc_wr && !mis) ? rdata : dout_q;
    end

    always_comb begin
        Listo   = state_q == FIN;
        Ocupado = !idle;
        Dataout = dout_q;
    end

    // An asynchronous reset drops state_q out of FIN immediately, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (state_q == FIN && wr_q && !mis)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[dir_al[ADDR_W-1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end

endmodule

// File: tb/tb_memoria_datos_espera.sv
// tb_memoria_datos_espera: directed scoreboard bench for the wait-state data memory.
// A second instance with zero wait states shares the stimulus to observe its latency.
module tb_memoria_datos_espera;

    localparam int W = 2;
    localparam logic [1:0] TB_BYTE = 2'b00;
    localparam logic [1:0] TB_HALF = 2'b01;
    localparam logic [1:0] TB_WORD = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        EscrMem, LeerMem, SignoExt;
    logic [7:0]  Direc;
    logic [31:0] Datain;
    logic [1:0]  Tam;
    logic [31:0] Dataout, Dataout0;
    logic        Listo, Ocupado, ErrAlin;
    logic        Listo0, Ocupado0, ErrAlin0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_dout = 32'h0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    memoria_datos_espera #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(W)) dut (
        .clk(clk), .reset(reset), .EscrMem(EscrMem), .LeerMem(LeerMem), .Direc(Direc),
        .Datain(Datain), .Tam(Tam), .SignoExt(SignoExt), .Dataout(Dataout),
        .Listo(Listo), .Ocupado(Ocupado), .ErrAlin(ErrAlin)
    );

    memoria_datos_espera #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .EscrMem(EscrMem), .LeerMem(LeerMem), .Direc(Direc),
        .Datain(Datain), .Tam(Tam), .SignoExt(SignoExt), .Dataout(Dataout0),
        .Listo(Listo0), .Ocupado(Ocupado0), .ErrAlin(ErrAlin0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One request held for a single edge; expected Dataout/ErrAlin pushed now, popped at Listo.
    task automatic access(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d,
                          input logic [1:0] t, input logic s, input logic [31:0] exp_rd,
                          input logic exp_err, input logic poke);
        int lat;
        int extra;
        logic [32:0] e;
        if (rd && !wr && !exp_err) exp_dout = exp_rd;
        sb.push_back({exp_err, exp_dout});
        @(negedge clk);
        EscrMem = wr; LeerMem = rd; Direc = a; Datain = d; Tam = t; SignoExt = s;
        @(negedge clk);
        EscrMem = 1'b0; LeerMem = 1'b0;
        chk("listo_wait0", {31'b0, Listo0}, 32'd1);
        lat = 1;
        while (!Listo && lat < 20) begin
            if (poke && lat == 1) begin LeerMem = 1'b1; Direc = 8'h10; Tam = TB_WORD; end
            @(negedge clk);
            LeerMem = 1'b0;
            lat++;
        end
        chk("latency", lat, W + 1);
        chk("ocupado_at_listo", {31'b0, Ocupado}, 32'd1);
        e = sb.size() > 0 ? sb.pop_front() : 33'bx;
        chk("dataout", Dataout, e[31:0]);
        chk("erralin", {31'b0, ErrAlin}, {31'b0, e[32]});
        if (poke) begin
            extra = 0;
            repeat (6) begin
                @(negedge clk);
                if (Listo) extra++;
            end
            chk("busy_request_ignored", extra, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset = 1'b1; EscrMem = 1'b0; LeerMem = 1'b0; Direc = '0; Datain = '0; Tam = '0; SignoExt = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dataout", Dataout, 32'h0);
        chk("rst_listo", {31'b0, Listo}, 32'd0);
        chk("rst_ocupado", {31'b0, Ocupado}, 32'd0);
        chk("rst_erralin", {31'b0, ErrAlin}, 32'd0);
        chk("rst0_dataout", Dataout0, 32'h0);
        chk("rst0_ocupado", {31'b0, Ocupado0}, 32'd0);
        chk("rst0_erralin", {31'b0, ErrAlin0}, 32'd0);

        access(1, 0, 8'h04, 32'h0000_0060, TB_WORD, 0, 32'h0, 0, 0);
        access(0, 1, 8'h04, 32'h0, TB_WORD, 0, 32'h0000_0060, 0, 0);

        access(1, 0, 8'h08, 32'h1122_3344, TB_WORD, 0, 32'h0, 0, 0);
        access(1, 0, 8'h09, 32'h0000_00AB, TB_BYTE, 0, 32'h0, 0, 0);
        access(0, 1, 8'h08, 32'h0, TB_WORD, 0, 32'h1122_AB44, 0, 0);
        access(1, 0, 8'h0A, 32'h0000_BEEF, TB_HALF, 0, 32'h0, 0, 0);
        access(0, 1, 8'h08, 32'h0, TB_WORD, 0, 32'hBEEF_AB44, 0, 0);

        access(0, 1, 8'h0B, 32'h0, TB_BYTE, 1, 32'hFFFF_FFBE, 0, 0);
        access(0, 1, 8'h0B, 32'h0, TB_BYTE, 0, 32'h0000_00BE, 0, 0);
        access(0, 1, 8'h0A, 32'h0, TB_HALF, 1, 32'hFFFF_BEEF, 0, 0);
        access(0, 1, 8'h08, 32'h0, TB_HALF, 0, 32'h0000_AB44, 0, 0);
        access(0, 1, 8'h08, 32'h0, TB_BYTE, 1, 32'h0000_0044, 0, 0);
        access(0, 1, 8'h09, 32'h0, 2'b11, 0, 32'hBEEF_AB44, 0, 0);

        access(1, 1, 8'h10, 32'h0000_0055, TB_WORD, 0, 32'h0, 0, 0);
        access(0, 1, 8'h10, 32'h0, TB_WORD, 0, 32'h0000_0055, 0, 0);
        access(0, 1, 8'h08, 32'h0, TB_WORD, 0, 32'hBEEF_AB44, 0, 1);

        access(1, 0, 8'h0C, 32'h1234_5678, TB_WORD, 0, 32'h0, 0, 0);
        @(negedge clk);
        EscrMem = 1'b1; Direc = 8'h0C; Datain = 32'h0000_00C0; Tam = TB_WORD;
        @(negedge clk);
        EscrMem = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        exp_dout = 32'h0;
        chk("midrst_ocupado", {31'b0, Ocupado}, 32'd0);
        chk("midrst_dataout", Dataout, 32'h0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (Listo) pulses++;
        end
        chk("midrst_no_listo", pulses, 0);
        access(0, 1, 8'h0C, 32'h0, TB_WORD, 0, 32'h1234_5678, 0, 0);

`ifdef MEM_ALIN_EN
        access(1, 0, 8'h0D, 32'hCAFE_F00D, TB_WORD, 0, 32'h0, 1, 0);
        access(0, 1, 8'h0C, 32'h0, TB_WORD, 0, 32'h1234_5678, 0, 0);
`else
        access(1, 0, 8'h0D, 32'hCAFE_F00D, TB_WORD, 0, 32'h0, 0, 0);
        access(0, 1, 8'h0C, 32'h0, TB_WORD, 0, 32'hCAFE_F00D, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
